ila_proc_param: RTL
===================

ILA_PROC_PARAM -- requirements
Module: ila_proc_param

Interface
REQ-001 Parameter DATA_W, default 8: register and ALU width in bits.
REQ-002 Parameter NREG, default 4: register count; power of 2 and at least 2; RIDX_W = log2(NREG).
REQ-003 Parameter IMEM_DEPTH, default 256: instruction memory depth; power of 2; PC_W = log2(IMEM_DEPTH).
REQ-004 Parameter CNT_W, default 8: width of each per-instruction counter.
REQ-005 Derived INSTR_W = 2 + 3*RIDX_W; instruction fields, MSB first: op[2], rd, rs1, rs2.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 run  in  1  execute enable.
REQ-009 imem_we  in  1  instruction memory write strobe.
REQ-010 imem_addr  in  PC_W  instruction memory write address.
REQ-011 imem_wdata  in  INSTR_W  instruction memory write data.
REQ-012 valid  out  1  high when run=1, rst=0 and imem_we=0.
REQ-013 dec_add, dec_sub, dec_and  out  1 each  decode of the current instruction, qualified by valid.
REQ-014 pc  out  PC_W  program counter.
REQ-015 regs  out  NREG*DATA_W  flattened register file; register i occupies bits [i*DATA_W +: DATA_W].
REQ-016 cnt_add, cnt_sub, cnt_and  out  CNT_W each  decode-since counters; present only under REQ-030.

Function
REQ-017 Instruction fetch SHALL be a combinational read of imem[pc].
REQ-018 Opcode map SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND.
REQ-019 dec_* SHALL be combinational: (op == code) AND valid.
REQ-020 When valid=1, each cycle SHALL execute exactly one instruction: pc <= pc+1, wrapping from IMEM_DEPTH-1 to 0.
- ADD/SUB/AND: regs[rd] <= regs[rs1] op regs[rs2], mod 2^DATA_W.
- NOP: register file unchanged.
REQ-021 Source operands SHALL be pre-edge values; rd equal to rs1 or rs2 is legal.
REQ-022 When valid=0, pc and regs SHALL hold.
REQ-023 imem_we=1 SHALL write imem_wdata to imem[imem_addr] and stall execution that cycle; the write has priority over execution.
REQ-024 imem SHALL NOT be reset; writes SHALL be ignored while rst=1.
REQ-025 Per-op counter rule:
- Decode of that op in a cycle: counter <= 1.
- Otherwise, if 1 <= counter < 2^CNT_W-1: counter += 1.
- Otherwise: counter holds, saturating at 2^CNT_W-1 or staying at 0.
REQ-026 Re-decode SHALL take priority over increment and saturation, restarting the counter at 1.
REQ-027 Counters SHALL advance every non-reset cycle, independent of run.

Reset
REQ-028 With rst=1 at a clock edge: pc, all registers and all counters SHALL be 0; valid=0 and dec_*=0 during the rst cycle.
REQ-029 Asserting rst mid-sequence SHALL discard the in-flight instruction, whose write SHALL NOT occur; execution resumes from pc=0.

Configuration
REQ-030 Macro ILA_PROC_COUNTER_EN:
- Defined: cnt_add, cnt_sub and cnt_and ports and their logic exist.
- Undefined: those ports and all counter logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package ila_proc_pkg SHALL hold the opcode enum (OP_NOP, OP_ADD, OP_SUB, OP_AND) and the opcode width constant (2).
REQ-032 Sub-module ila_field_dec SHALL take an instruction and output op, rd, rs1 and rs2, parametrised by RIDX_W; it SHALL be instantiated once.

Verification
REQ-033 Defaults; load imem[0]=ADD r1,r2,r3 with r2=0x05 and r3=0x07; run=1 -> after 1 cycle: r1=0x0C, pc=1, cnt_add=1.
REQ-034 SUB r0,r0,r1 with r0=0x00 and r1=0x01 -> r0=0xFF (wrap); NOP -> regs unchanged, pc+1.
REQ-035 pc=255, run=1 -> pc=0 next cycle; imem_we=1 with run=1 -> pc holds and imem is written.
REQ-036 One ADD, then 300 NOP cycles -> cnt_add=1,2,...,255, then holds at 255; a new ADD at any point -> cnt_add=1.
REQ-037 rst=1 asserted in the same cycle as ADD r1 -> r1 unchanged (0 after reset), pc=0, counters=0; imem contents retained.
REQ-038 Parameters NREG=8, DATA_W=16, IMEM_DEPTH=16: ADD r7,r6,r5 with 0xFFFF+0x0002 -> r7=0x0001; build without ILA_PROC_COUNTER_EN elaborates without cnt ports.

Source files
------------

// File: rtl/ila_proc_pkg.sv
// Shared opcode definitions for the ila_proc_param register machine.
package ila_proc_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_AND = 2'd3
  } op_e;

endpackage

// File: rtl/ila_field_dec.sv
// Splits an instruction word into opcode and register index fields (MSB first: op, rd, rs1, rs2).
module ila_field_dec
  import ila_proc_pkg::*;
#(
  parameter int unsigned RIDX_W = 2
) (
  input  logic [OP_W+3*RIDX_W-1:0] instr,
  output op_e                      op,
  output logic [RIDX_W-1:0]        rd,
  output logic [RIDX_W-1:0]        rs1,
  output logic [RIDX_W-1:0]        rs2
);

  assign op  = op_e'(instr[OP_W+3*RIDX_W-1 -: OP_W]);
  assign rd  = instr[3*RIDX_W-1 -: RIDX_W];
  assign rs1 = instr[2*RIDX_W-1 -: RIDX_W];
  assign rs2 = instr[RIDX_W-1:0];

endmodule

// File: rtl/ila_proc_param.sv
// Tiny parameterised register machine with writable instruction memory and per-op decode counters.
// Define ILA_PROC_COUNTER_EN to build the cnt_add/cnt_sub/cnt_and ports and counter logic.
module ila_proc_param
  import ila_proc_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREG       = 4,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned RIDX_W    = $clog2(NREG),
  localparam int unsigned PC_W      = $clog2(IMEM_DEPTH),
  localparam int unsigned INSTR_W   = OP_W + 3 * RIDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   imem_we,
  input  logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_wdata,
  output logic                   valid,
  output logic                   dec_add,
  output logic                   dec_sub,
  output logic                   dec_and,
`ifdef ILA_PROC_COUNTER_EN
  output logic [CNT_W-1:0]       cnt_add,
  output logic [CNT_W-1:0]       cnt_sub,
  output logic [CNT_W-1:0]       cnt_and,
`endif
  output logic [PC_W-1:0]        pc,
  output logic [NREG*DATA_W-1:0] regs
);

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [PC_W-1:0]    pc_q;
  logic [DATA_W-1:0]  rf_q [NREG];

  logic [INSTR_W-1:0] instr;
  op_e                op;
  logic [RIDX_W-1:0]  rd;
  logic [RIDX_W-1:0]  rs1;
  logic [RIDX_W-1:0]  rs2;
  logic [DATA_W-1:0]  alu;

  // Instruction memory is deliberately left out of reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (!rst && imem_we) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  assign instr = imem[pc_q];

  ila_field_dec #(
    .RIDX_W (RIDX_W)
  ) u_field_dec (
    .instr (instr),
    .op    (op),
    .rd    (rd),
    .rs1   (rs1),
    .rs2   (rs2)
  );

  assign valid   = run & ~rst & ~imem_we;
  assign dec_add = valid & (op == OP_ADD);
  assign dec_sub = valid & (op == OP_SUB);
  assign dec_and = valid & (op == OP_AND);

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rf_q[rs1] + rf_q[rs2];
      OP_SUB:  alu = rf_q[rs1] - rf_q[rs2];
      OP_AND:  alu = rf_q[rs1] & rf_q[rs2];
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (valid) begin
      pc_q <= pc_q + PC_W'(1);
      if (op != OP_NOP) begin
        rf_q[rd] <= alu;
      end
    end
  end

  assign pc = pc_q;

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = rf_q[g];
  end

`ifdef ILA_PROC_COUNTER_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       dec_vec;
  logic [CNT_W-1:0] cnt_q [3];

  assign dec_vec = {dec_and, dec_sub, dec_add};

  // A counter at 0 has never seen its op since reset and stays idle until the first decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (dec_vec[i]) begin
          cnt_q[i] <= CNT_W'(1);
        end else if (cnt_q[i] != '0 && cnt_q[i] != CNT_MAX) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_add = cnt_q[0];
  assign cnt_sub = cnt_q[1];
  assign cnt_and = cnt_q[2];
`endif

endmodule
